// File: rtl/mux_nx1_stream.sv
// N-to-1 registered valid/ready stream multiplexer with a single output slot.
// Channel selection is either an external select (MODE=0) or round-robin (MODE=1).
module mux_nx1_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned MODE  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N*WIDTH-1:0]     in_data,
    input  logic [N-1:0]           in_valid,
    output logic [N-1:0]           in_ready,
    input  logic [$clog2(N)-1:0]   sel,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(N)-1:0]   out_chan,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int unsigned SELW = $clog2(N);
    localparam logic [SELW:0] NumCh = (SELW + 1)'(N);

    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;

    logic [SELW-1:0]  grant;
    logic             grant_valid;
    logic [SELW:0]    idx;
    logic [WIDTH-1:0] grant_data;
    logic             load_en;
    logic             transfer;

    // One extra bit on idx keeps rr_ptr + k from wrapping before the modulo-N fold.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        if (MODE == 0) begin
            grant       = sel;
            grant_valid = ({1'b0, sel} < NumCh);
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                idx = {1'b0, rr_ptr_q} + (SELW + 1)'(k);
                if (idx >= NumCh) begin
                    idx = idx - NumCh;
                end
                if (!grant_valid && in_valid[idx[SELW-1:0]]) begin
                    grant_valid = 1'b1;
                    grant       = idx[SELW-1:0];
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant == SELW'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign load_en  = !out_valid_q || out_ready;
    assign in_ready = (load_en && grant_valid && !rst) ? (N'(1) << grant) : '0;
    assign transfer = |(in_ready & in_valid);

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        if (transfer) begin
            out_data_d  = grant_data;
            out_chan_d  = grant;
            out_valid_d = 1'b1;
            if (MODE != 0) begin
                rr_ptr_d = (grant == SELW'(N - 1)) ? '0 : grant + 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Bench for mux_nx1_stream: three instances (N=4 select, N=4 round-robin, N=5 select)
// driven from directed vector tables and random traffic against a slot-level model.
module tb_mux_nx1_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: N=4, MODE=0
    logic        a_rst, a_ordy, a_ovalid;
    logic [31:0] a_data;
    logic [3:0]  a_valid, a_ready;
    logic [1:0]  a_sel, a_chan;
    logic [7:0]  a_odata;
    // Instance 1: N=4, MODE=1
    logic        b_rst, b_ordy, b_ovalid;
    logic [31:0] b_data;
    logic [3:0]  b_valid, b_ready;
    logic [1:0]  b_sel, b_chan;
    logic [7:0]  b_odata;
    // Instance 2: N=5, MODE=0
    logic        c_rst, c_ordy, c_ovalid;
    logic [39:0] c_data;
    logic [4:0]  c_valid, c_ready;
    logic [2:0]  c_sel, c_chan;
    logic [7:0]  c_odata;

    mux_nx1_stream #(.WIDTH(8), .N(4), .MODE(0)) u_sel4 (
        .clk(clk), .rst(a_rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .sel(a_sel), .out_data(a_odata), .out_chan(a_chan), .out_valid(a_ovalid),
        .out_ready(a_ordy)
    );
    mux_nx1_stream #(.WIDTH(8), .N(4), .MODE(1)) u_rr4 (
        .clk(clk), .rst(b_rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .sel(b_sel), .out_data(b_odata), .out_chan(b_chan), .out_valid(b_ovalid),
        .out_ready(b_ordy)
    );
    mux_nx1_stream #(.WIDTH(8), .N(5), .MODE(0)) u_sel5 (
        .clk(clk), .rst(c_rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
        .sel(c_sel), .out_data(c_odata), .out_chan(c_chan), .out_valid(c_ovalid),
        .out_ready(c_ordy)
    );

    typedef struct {
        int          id;
        logic        rst;
        logic [39:0] data;
        logic [4:0]  valid;
        logic [2:0]  sel;
        logic        ordy;
        logic [4:0]  e_ready;
        logic        e_valid;
        logic [7:0]  e_data;
        int          e_chan;
    } vec_t;

    vec_t vecs[$];

    int total = 0;
    int bad   = 0;
    int cur_id;
    int cyc = 0;

    // Slot-level reference model, one entry per instance.
    logic       m_valid[3];
    logic [7:0] m_data[3];
    int         m_chan[3];
    int         m_ptr[3];

    logic [4:0] g_ready;
    logic       g_valid;
    logic [7:0] g_data;
    int         g_chan;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h", name, cur_id, cyc, got, exp);
        end
    endtask

    task automatic add(input int id, input logic r, input logic [39:0] d, input logic [4:0] v,
                       input logic [2:0] s, input logic o, input logic [4:0] er,
                       input logic ev, input logic [7:0] ed, input int ec);
        vec_t t;
        t.id = id; t.rst = r; t.data = d; t.valid = v; t.sel = s; t.ordy = o;
        t.e_ready = er; t.e_valid = ev; t.e_data = ed; t.e_chan = ec;
        vecs.push_back(t);
    endtask

    // Drive one cycle on one instance, check against the model before the edge,
    // then advance the model across the edge.
    task automatic step(input int id, input logic r, input logic [39:0] d, input logic [4:0] v,
                        input logic [2:0] s, input logic o);
        int         n;
        bit         rr;
        bit         gv;
        int         g;
        int         ix;
        logic [4:0] e_ready;
        bit         xfer;
        cur_id = id;
        n  = (id == 2) ? 5 : 4;
        rr = (id == 1);
        case (id)
            0: begin a_rst = r; a_data = d[31:0]; a_valid = v[3:0]; a_sel = s[1:0]; a_ordy = o; end
            1: begin b_rst = r; b_data = d[31:0]; b_valid = v[3:0]; b_sel = s[1:0]; b_ordy = o; end
            default: begin c_rst = r; c_data = d; c_valid = v; c_sel = s; c_ordy = o; end
        endcase
        #4;
        case (id)
            0: begin g_ready = {1'b0, a_ready}; g_valid = a_ovalid; g_data = a_odata; g_chan = int'(a_chan); end
            1: begin g_ready = {1'b0, b_ready}; g_valid = b_ovalid; g_data = b_odata; g_chan = int'(b_chan); end
            default: begin g_ready = c_ready; g_valid = c_ovalid; g_data = c_odata; g_chan = int'(c_chan); end
        endcase

        gv = 0;
        g  = 0;
        if (!rr) begin
            if (int'(s) < n) begin gv = 1; g = int'(s); end
        end else begin
            for (int k = 0; k < n; k++) begin
                ix = (m_ptr[id] + k) % n;
                if (!gv && v[ix]) begin gv = 1; g = ix; end
            end
        end
        e_ready = (!r && (!m_valid[id] || o) && gv) ? 5'(1 << g) : 5'd0;
        xfer = (e_ready & v) != 5'd0;

        chk("ready", int'(g_ready), int'(e_ready));
        chk("out_valid", int'(g_valid), int'(m_valid[id]));
        chk("out_data", int'(g_data), int'(m_data[id]));
        chk("out_chan", g_chan, m_chan[id]);

        @(posedge clk);
        if (r) begin
            m_valid[id] = 0; m_data[id] = 8'h00; m_chan[id] = 0; m_ptr[id] = 0;
        end else if (xfer) begin
            m_valid[id] = 1;
            m_data[id]  = d[g*8 +: 8];
            m_chan[id]  = g;
            if (rr) m_ptr[id] = (g == n - 1) ? 0 : g + 1;
        end else if (m_valid[id] && o) begin
            m_valid[id] = 0;
        end
        cyc++;
        #1;
    endtask

    logic [39:0] D0, D1, D2, rd;
    logic [4:0]  rv;
    logic [2:0]  rs;

    initial begin
        a_rst = 1; a_data = '0; a_valid = '0; a_sel = '0; a_ordy = 0;
        b_rst = 1; b_data = '0; b_valid = '0; b_sel = '0; b_ordy = 0;
        c_rst = 1; c_data = '0; c_valid = '0; c_sel = '0; c_ordy = 0;
        for (int i = 0; i < 3; i++) begin
            m_valid[i] = 0; m_data[i] = 8'h00; m_chan[i] = 0; m_ptr[i] = 0;
        end
        @(posedge clk);
        #1;

        D0 = 40'h0011A53344;   // ch0=44 ch1=33 ch2=A5 ch3=11
        D1 = 40'h0044332211;   // ch0=11 ch1=22 ch2=33 ch3=44
        D2 = 40'h5504030201;   // ch0..ch4 = 01 02 03 04 55

        // Select mode: reset, load, backpressure, drain+fill, ready without valid, reset when full.
        add(0, 1, D0, 5'h0F, 3'd2, 1, 5'b00000, 0, 8'h00, 0);
        add(0, 1, D0, 5'h0F, 3'd2, 1, 5'b00000, 0, 8'h00, 0);
        add(0, 0, D0, 5'b00100, 3'd2, 1, 5'b00100, 0, 8'h00, 0);
        add(0, 0, D0, 5'b00010, 3'd1, 0, 5'b00000, 1, 8'hA5, 2);
        add(0, 0, D0, 5'b00010, 3'd1, 0, 5'b00000, 1, 8'hA5, 2);
        add(0, 0, D0, 5'b00010, 3'd1, 0, 5'b00000, 1, 8'hA5, 2);
        add(0, 0, D0, 5'b00010, 3'd1, 1, 5'b00010, 1, 8'hA5, 2);
        add(0, 0, D0, 5'b00000, 3'd1, 0, 5'b00000, 1, 8'h33, 1);
        add(0, 0, D0, 5'b00000, 3'd1, 1, 5'b00010, 1, 8'h33, 1);
        add(0, 0, D0, 5'b00000, 3'd1, 1, 5'b00010, 0, 8'h33, 1);
        add(0, 0, D0, 5'b01000, 3'd3, 0, 5'b01000, 0, 8'h33, 1);
        add(0, 1, D0, 5'b01000, 3'd3, 0, 5'b00000, 1, 8'h11, 3);
        add(0, 0, D0, 5'b00000, 3'd0, 0, 5'b00001, 0, 8'h00, 0);
        // Round-robin: all valid, then ch1/ch3, then ch1 alone, then idle.
        add(1, 1, D1, 5'h0F, 3'd0, 1, 5'b00000, 0, 8'h00, 0);
        add(1, 0, D1, 5'h0F, 3'd0, 1, 5'b00001, 0, 8'h00, 0);
        add(1, 0, D1, 5'h0F, 3'd0, 1, 5'b00010, 1, 8'h11, 0);
        add(1, 0, D1, 5'h0F, 3'd0, 1, 5'b00100, 1, 8'h22, 1);
        add(1, 0, D1, 5'h0F, 3'd0, 1, 5'b01000, 1, 8'h33, 2);
        add(1, 0, D1, 5'h0F, 3'd0, 1, 5'b00001, 1, 8'h44, 3);
        add(1, 0, D1, 5'h0F, 3'd0, 1, 5'b00010, 1, 8'h11, 0);
        add(1, 0, D1, 5'b01010, 3'd0, 1, 5'b01000, 1, 8'h22, 1);
        add(1, 0, D1, 5'b01010, 3'd0, 1, 5'b00010, 1, 8'h44, 3);
        add(1, 0, D1, 5'b01010, 3'd0, 1, 5'b01000, 1, 8'h22, 1);
        add(1, 0, D1, 5'b01010, 3'd0, 1, 5'b00010, 1, 8'h44, 3);
        add(1, 0, D1, 5'b00010, 3'd0, 1, 5'b00010, 1, 8'h22, 1);
        add(1, 0, D1, 5'b00010, 3'd0, 1, 5'b00010, 1, 8'h22, 1);
        add(1, 0, D1, 5'b00000, 3'd0, 1, 5'b00000, 1, 8'h22, 1);
        add(1, 0, D1, 5'b00000, 3'd0, 1, 5'b00000, 0, 8'h22, 1);
        // N=5: out-of-range select grants nothing; sel=4 loads ch4.
        add(2, 1, D2, 5'h1F, 3'd6, 1, 5'b00000, 0, 8'h00, 0);
        add(2, 0, D2, 5'h1F, 3'd6, 1, 5'b00000, 0, 8'h00, 0);
        add(2, 0, D2, 5'h1F, 3'd6, 1, 5'b00000, 0, 8'h00, 0);
        add(2, 0, D2, 5'h1F, 3'd4, 1, 5'b10000, 0, 8'h00, 0);
        add(2, 0, D2, 5'h00, 3'd4, 1, 5'b10000, 1, 8'h55, 4);
        add(2, 0, D2, 5'h00, 3'd7, 1, 5'b00000, 0, 8'h55, 4);

        foreach (vecs[i]) begin
            step(vecs[i].id, vecs[i].rst, vecs[i].data, vecs[i].valid, vecs[i].sel, vecs[i].ordy);
            chk("tbl_ready", int'(g_ready), int'(vecs[i].e_ready));
            chk("tbl_valid", int'(g_valid), int'(vecs[i].e_valid));
            chk("tbl_data", int'(g_data), int'(vecs[i].e_data));
            chk("tbl_chan", g_chan, vecs[i].e_chan);
        end

        // Random traffic with occasional resets, checked only against the model.
        for (int id = 0; id < 3; id++) begin
            for (int c = 0; c < 400; c++) begin
                rd[31:0]  = $urandom;
                rd[39:32] = 8'($urandom);
                rv        = 5'($urandom);
                rs        = (id == 2) ? 3'($urandom_range(7, 0)) : 3'($urandom_range(3, 0));
                step(id, ($urandom_range(49, 0) == 0), rd, rv, rs, 1'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
